// File: rtl/fifo_rd_packer_if.sv
// Bundle between fifo_rd_packer and its environment: upstream FIFO read port,
// flush request and the downstream valid/ready word channel.
interface fifo_rd_packer_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 3;

  logic                fifo_empty;
  logic [BYTE_W-1:0]   fifo_rdata;
  logic                fifo_ren;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_data;
  logic [LANES-1:0]    out_keep;
  logic [CNT_W-1:0]    bytes_pending;

  // Packer side
  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_keep, bytes_pending
  );

  // Environment side (FIFO, flush source, word consumer)
  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_keep, bytes_pending
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops bytes from an upstream FIFO and packs them little-endian into 32-bit words.
// Optional idle-timeout partial-word emit is enabled with macro PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_rd_packer_if.master  bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {S_ASSEMBLE = 1'b0, S_OUTPUT = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_data;
  logic [WORD_W-1:0]   w_data_nxt;
  logic [LANES-1:0]    r_keep;
  logic [LANES-1:0]    w_keep_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_pop;
  logic                w_timeout;

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = 8;

  logic [IDLE_W-1:0]   r_idle;
  logic [IDLE_W-1:0]   w_idle_nxt;

  // Fires on the edge where the idle count would reach TIMEOUT
  assign w_timeout = (r_state == S_ASSEMBLE) && bus.fifo_empty && (r_cnt != '0) &&
                     ((r_idle + IDLE_W'(1)) == IDLE_W'(TIMEOUT));

  always_comb begin
    w_idle_nxt = r_idle;
    if ((w_state_nxt != r_state) || w_pop) begin
      w_idle_nxt = '0;
    end else if ((r_state == S_ASSEMBLE) && (r_cnt != '0)) begin
      w_idle_nxt = r_idle + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_keep_nxt  = r_keep;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_ASSEMBLE: begin
        w_pop = !bus.fifo_empty;
        if (w_pop) begin
          w_data_nxt[{r_cnt[1:0], 3'b000} +: BYTE_W] = bus.fifo_rdata;
          w_keep_nxt[r_cnt[1:0]]                     = 1'b1;
          w_cnt_nxt                                  = r_cnt + CNT_W'(1);
        end
        // A flush counts bytes popped in the same cycle
        if ((w_cnt_nxt == CNT_W'(LANES)) ||
            ((bus.flush || w_timeout) && (w_cnt_nxt != '0))) begin
          w_state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          w_state_nxt = S_ASSEMBLE;
          w_data_nxt  = '0;
          w_keep_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_ASSEMBLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ASSEMBLE;
      r_data  <= '0;
      r_keep  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_keep  <= w_keep_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.fifo_ren      = w_pop;
  assign bus.out_valid     = (r_state == S_OUTPUT);
  assign bus.out_data      = r_data;
  assign bus.out_keep      = r_keep;
  assign bus.bytes_pending = r_cnt;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed table, corner sequences and
// randomized traffic against a byte-list reference model.
module tb_fifo_rd_packer;
  localparam int unsigned TB_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;

  fifo_rd_packer_if bus();

  fifo_rd_packer #(.TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Upstream FIFO contents
  logic [7:0] q[$];

  // Reference model: bytes collected so far, whether a word is presented, idle count
  logic [7:0] m_bytes[$];
  bit         m_pres;
  int         m_idle;

  typedef struct {
    bit          push;
    logic [7:0]  b;
    bit          flush;
    bit          ready;
    bit          e_ren;
    bit          e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic [2:0]  e_pend;
  } row_t;

  row_t tbl[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {23'd0, bus.out_valid, bus.fifo_ren, bus.bytes_pending, bus.out_keep, bus.out_data};
  endfunction

  function automatic logic [63:0] model_vec();
    logic [31:0] d;
    logic [3:0]  k;
    logic        ren;
    d = '0;
    k = '0;
    for (int i = 0; i < m_bytes.size(); i++) begin
      d = d | (32'(m_bytes[i]) << (8 * i));
      k[i] = 1'b1;
    end
    ren = !m_pres && (q.size() > 0);
    return {23'd0, m_pres, ren, 3'(m_bytes.size()), k, d};
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    m_pres = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_advance(input bit flush, input bit ready);
    bit tmo;
    tmo = 1'b0;
    if (m_pres) begin
      if (ready) begin
        m_pres = 1'b0;
        m_bytes.delete();
      end
      m_idle = 0;
    end else begin
      if (q.size() > 0) begin
        m_bytes.push_back(q[0]);
        m_idle = 0;
      end else if (m_bytes.size() > 0) begin
        m_idle++;
`ifdef PACKER_TIMEOUT_EN
        tmo = (m_idle == int'(TB_TIMEOUT));
`endif
      end
      if (m_bytes.size() == 4) m_pres = 1'b1;
      else if ((flush || tmo) && (m_bytes.size() > 0)) m_pres = 1'b1;
      if (m_pres) m_idle = 0;
    end
  endtask

  task automatic settle();
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_rdata = (q.size() > 0) ? q[0] : 8'h00;
    #1;
  endtask

  // Called settled, just after a falling edge; advances one clock
  task automatic step();
    logic ren;
    check($sformatf("model@%0d", cyc), dut_vec(), model_vec());
    ren = bus.fifo_ren;
    model_advance(bus.flush, bus.out_ready);
    @(posedge clk);
    @(negedge clk);
    if (ren && (q.size() > 0)) void'(q.pop_front());
    cyc++;
  endtask

  task automatic tick();
    settle();
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;

    tbl[0]  = '{0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[1]  = '{0, 8'h00, 0, 1, 1, 0, 32'h11,       4'h1, 3'd1};
    tbl[2]  = '{0, 8'h00, 0, 1, 1, 0, 32'h2211,     4'h3, 3'd2};
    tbl[3]  = '{0, 8'h00, 0, 1, 1, 0, 32'h332211,   4'h7, 3'd3};
    tbl[4]  = '{0, 8'h00, 0, 1, 0, 1, 32'h44332211, 4'hF, 3'd4};
    tbl[5]  = '{1, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0, 3'd0};
    tbl[6]  = '{1, 8'hBB, 0, 1, 1, 0, 32'hAA,       4'h1, 3'd1};
    tbl[7]  = '{0, 8'h00, 1, 1, 0, 0, 32'hBBAA,     4'h3, 3'd2};
    tbl[8]  = '{0, 8'h00, 0, 0, 0, 1, 32'hBBAA,     4'h3, 3'd2};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 1, 32'hBBAA,     4'h3, 3'd2};
    tbl[10] = '{0, 8'h00, 1, 1, 0, 0, 32'h0,        4'h0, 3'd0};
    tbl[11] = '{0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 3'd0};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    settle();
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_data",  64'(bus.out_data), 64'd0);
    check("reset_keep",  64'(bus.out_keep), 64'd0);
    check("reset_pend",  64'(bus.bytes_pending), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: full word, partial flush, flush with nothing pending
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push) q.push_back(tbl[i].b);
      bus.flush     = tbl[i].flush;
      bus.out_ready = tbl[i].ready;
      settle();
      check($sformatf("tbl[%0d]", i),
            {23'd0, bus.out_valid, bus.fifo_ren, bus.bytes_pending, bus.out_keep, bus.out_data},
            {23'd0, tbl[i].e_valid, tbl[i].e_ren, tbl[i].e_pend, tbl[i].e_keep, tbl[i].e_data});
      step();
    end
    bus.flush = 1'b0;

    // Backpressure: word held for 10 cycles, bubble after the handshake
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    q.push_back(8'h55);
    bus.out_ready = 1'b0;
    n = 0;
    settle();
    while (!bus.out_valid && n < 10) begin
      step();
      settle();
      n++;
    end
    check("bp_fill_cycles", 64'(n), 64'd4);
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_hold_ren",  64'(bus.fifo_ren), 64'd0);
      check("bp_hold_data", 64'(bus.out_data), 64'h44332211);
      step();
    end
    bus.out_ready = 1'b1;
    settle();
    check("bp_hs_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hs_ren",   64'(bus.fifo_ren), 64'd0);
    step();
    settle();
    check("bp_after_valid", 64'(bus.out_valid), 64'd0);
    check("bp_after_ren",   64'(bus.fifo_ren), 64'd1);
    step();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();

    // Idle timeout on a single pending byte
    bus.out_ready = 1'b0;
    q.push_back(8'h5A);
    tick();
    n = 0;
    settle();
    while (!bus.out_valid && n < 30) begin
      step();
      settle();
      n++;
    end
`ifdef PACKER_TIMEOUT_EN
    check("tmo_idle_cycles", 64'(n), 64'(TB_TIMEOUT));
    check("tmo_data", 64'(bus.out_data), 64'h5A);
    check("tmo_keep", 64'(bus.out_keep), 64'h1);
`else
    check("tmo_absent_valid", 64'(bus.out_valid), 64'd0);
    check("tmo_absent_pend",  64'(bus.bytes_pending), 64'd1);
`endif
    bus.flush = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Reset mid-word discards partial bytes
    q.push_back(8'hE1); q.push_back(8'hE2); q.push_back(8'hE3);
    tick(); tick(); tick();
    settle();
    check("pre_rst_pend", 64'(bus.bytes_pending), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pend",  64'(bus.bytes_pending), 64'd0);
    check("rst_keep",  64'(bus.out_keep), 64'd0);
    check("rst_data",  64'(bus.out_data), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
    n = 0;
    settle();
    while (!bus.out_valid && n < 10) begin
      step();
      settle();
      n++;
    end
    check("post_rst_data", 64'(bus.out_data), 64'h04030201);
    check("post_rst_keep", 64'(bus.out_keep), 64'hF);
    bus.out_ready = 1'b1;
    tick();

    // Randomized traffic with periodic quiet phases to exercise partial words
    for (int i = 0; i < 600; i++) begin
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (((i / 40) % 3) != 2 && q.size() < 8 && $urandom_range(0, 1) == 1)
        q.push_back(8'($urandom_range(0, 255)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the idle cycles before an automatic partial-word emit (range 1..255; used only with PACKER_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fifo_empty  input  1  upstream FIFO holds no data.
REQ-005 SHALL have port fifo_rdata  input  8  upstream read data, combinationally valid while fifo_empty=0.
REQ-006 SHALL have port fifo_ren  output  1  pops one byte from the upstream FIFO at this edge.
REQ-007 SHALL have port flush  input  1  request to emit the pending partial word.
REQ-008 SHALL have port out_valid  output  1  out_data/out_keep hold a word.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port out_data  output  32  packed word, first byte in [7:0].
REQ-011 SHALL have port out_keep  output  4  valid-byte mask, bit i covers out_data[8i+7:8i].
REQ-012 SHALL have port bytes_pending  output  3  bytes currently held in the assembly register, 0..4.

Function
REQ-013 SHALL implement two states: ASSEMBLE (collecting bytes) and OUTPUT (word presented).
REQ-014 In ASSEMBLE, fifo_ren SHALL equal !fifo_empty (combinational); in OUTPUT, fifo_ren SHALL be 0.
REQ-015 Each edge with fifo_ren=1 SHALL store fifo_rdata into byte lane bytes_pending, set that keep bit, and increment bytes_pending.
REQ-016 The edge that stores the 4th byte SHALL move to OUTPUT with out_valid=1 and out_keep=4'hF on the next cycle.
REQ-017 flush=1 in ASSEMBLE SHALL move to OUTPUT at that edge if bytes_pending>0 after including any byte popped in the same cycle; otherwise it is ignored.
REQ-018 flush in OUTPUT SHALL be ignored; it is not remembered.
REQ-019 Unfilled byte lanes of a partial word SHALL read 0.
REQ-020 out_data and out_keep SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 An edge with out_valid=1 and out_ready=1 SHALL clear the data, keep, and bytes_pending registers, drop out_valid, and return to ASSEMBLE, so the next pop occurs no earlier than the following cycle (one-cycle bubble).
REQ-022 out_valid SHALL depend only on registered state, never combinationally on out_ready.

Reset
REQ-023 rst_n=0 SHALL immediately force state=ASSEMBLE, out_valid=0, out_data=0, out_keep=0, bytes_pending=0, and the idle counter=0.
REQ-024 Reset mid-word SHALL discard any partially assembled bytes; fifo_ren SHALL follow REQ-014 from the first edge after release.

Configuration
REQ-025 Macro PACKER_TIMEOUT_EN defined: an 8-bit idle counter SHALL count ASSEMBLE cycles with bytes_pending>0 and fifo_ren=0, reset to 0 on any pop or state change, and trigger an implicit flush at the edge where it reaches TIMEOUT.
REQ-026 Macro PACKER_TIMEOUT_EN undefined: no idle counter SHALL exist, and partial words SHALL be emitted only by flush.

Verification
REQ-027 FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> fifo_ren high for 4 cycles, then one out_valid cycle with out_data=0x44332211 and out_keep=4'hF.
REQ-028 Same data with out_ready=0 for 10 cycles, then 1 -> out_data held at 0x44332211 and fifo_ren=0 throughout; handshake occurs on the first ready edge; fifo_ren returns high no earlier than the next cycle.
REQ-029 Two bytes 0xAA,0xBB, then flush -> out_data=0x0000BBAA, out_keep=4'b0011.
REQ-030 flush with bytes_pending=0 and fifo_empty=1 -> out_valid stays 0 and state stays ASSEMBLE.
REQ-031 rst_n pulsed low after 3 bytes are popped -> bytes_pending=0 and out_keep=0; the next 4 bytes 0x01..0x04 produce exactly 0x04030201.
REQ-032 With PACKER_TIMEOUT_EN and TIMEOUT=8: one byte 0x5A, then FIFO stays empty -> out_valid rises after exactly 8 idle cycles with out_data=0x0000005A and out_keep=4'b0001; without the macro, out_valid stays 0.
